// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller for a 0-59 two-digit BCD seconds counter.
// Synchronises and debounces the start/stop and lap buttons, divides clk_in into
// one-cycle count ticks and sequences IDLE/RUN/LAP/PAUSE, freezing a lap snapshot
// for the display path.
//
// Ports:
//   clk_in     system clock, all state on rising edge
//   sw         asynchronous active-high reset
//   btn_start  raw start/stop button (asynchronous)
//   btn_lap    raw lap/clear button (asynchronous)
//   ones_in    counter ones digit (BCD)
//   tens_in    counter tens digit (BCD)
//   cnt_tick   one-cycle advance pulse to the counter
//   cnt_clr    level clear to the counter, high while IDLE
//   min_pulse  one-cycle pulse alongside the tick that wraps 59 -> 00
//   disp_ones  display ones digit
//   disp_tens  display tens digit
//   running    high in RUN or LAP
//   lap_active high in LAP
module stopwatch_ctrl #(
  parameter int unsigned DIV       = 100_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       clk_in,
  input  logic       sw,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic [3:0] ones_in,
  input  logic [3:0] tens_in,
  output logic       cnt_tick,
  output logic       cnt_clr,
  output logic       min_pulse,
  output logic [3:0] disp_ones,
  output logic [3:0] disp_tens,
  output logic       running,
  output logic       lap_active
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DbW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

  // Index 0 = start, index 1 = lap.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1_q, sync2_q, db_lvl_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [1:0]     press;
  logic           start_ev, lap_ev;

  state_e          state_q, state_d;
  logic            from_lap_q;
  logic [PreW-1:0] presc_q;
  logic [3:0]      lap_ones_q, lap_tens_q;
  logic            counting, wrap;

  assign btn_raw = {btn_lap, btn_start};

  // Synchroniser plus debouncer: a new level is accepted only after it has been
  // seen on the synchronised input for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk_in or posedge sw) begin
    if (sw) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_lvl_q    <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != db_lvl_q[i]) begin
          if (db_cnt_q[i] == DbLast) begin
            db_lvl_q[i] <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Press event fires in the cycle the accepted level is about to rise.
  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++) begin
      press[i] = sync2_q[i] & ~db_lvl_q[i] & (db_cnt_q[i] == DbLast);
    end
  end

  // Start wins over a simultaneous lap press.
  assign start_ev = press[0];
  assign lap_ev   = press[1] & ~press[0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ev) state_d = StRun;
      StRun: begin
        if (start_ev)    state_d = StPause;
        else if (lap_ev) state_d = StLap;
      end
      StLap: begin
        if (start_ev)    state_d = StPause;
        else if (lap_ev) state_d = StRun;
      end
      StPause: begin
        if (start_ev)    state_d = StRun;
        else if (lap_ev) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign counting = (state_q == StRun) || (state_q == StLap);
  assign wrap     = counting && (presc_q == PreLast);

  always_ff @(posedge clk_in or posedge sw) begin
    if (sw) begin
      state_q    <= StIdle;
      from_lap_q <= 1'b0;
      presc_q    <= '0;
      lap_ones_q <= 4'd0;
      lap_tens_q <= 4'd0;
      cnt_tick   <= 1'b0;
      cnt_clr    <= 1'b1;
      min_pulse  <= 1'b0;
      disp_ones  <= 4'd0;
      disp_tens  <= 4'd0;
      running    <= 1'b0;
      lap_active <= 1'b0;
    end else begin
      state_q <= state_d;

      // Remembers that PAUSE was entered from LAP so the snapshot stays shown.
      if (state_q == StLap && state_d == StPause) begin
        from_lap_q <= 1'b1;
      end else if (state_q == StPause && state_d != StPause) begin
        from_lap_q <= 1'b0;
      end

      // Prescaler holds in PAUSE so a resume keeps the tick phase.
      if (state_q == StIdle || wrap) begin
        presc_q <= '0;
      end else if (counting) begin
        presc_q <= presc_q + PreW'(1);
      end

      cnt_tick  <= wrap;
      min_pulse <= wrap && (ones_in == 4'd9) && (tens_in == 4'd5);

      cnt_clr    <= (state_d == StIdle);
      running    <= (state_d == StRun) || (state_d == StLap);
      lap_active <= (state_d == StLap);

      if (state_q == StRun && state_d == StLap) begin
        lap_ones_q <= ones_in;
        lap_tens_q <= tens_in;
      end

      if (state_q == StIdle) begin
        disp_ones <= 4'd0;
        disp_tens <= 4'd0;
      end else if (state_q == StLap || (state_q == StPause && from_lap_q)) begin
        disp_ones <= lap_ones_q;
        disp_tens <= lap_tens_q;
      end else begin
        disp_ones <= ones_in;
        disp_tens <= tens_in;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  logic       clk_in = 1'b0;
  logic       sw = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic [3:0] ones_in = 4'd0;
  logic [3:0] tens_in = 4'd0;
  logic       cnt_tick, cnt_clr, min_pulse, running, lap_active;
  logic [3:0] disp_ones, disp_tens;

  int   vectors = 0;
  int   miscompares = 0;
  logic seen;

  always #5 clk_in = ~clk_in;

  stopwatch_ctrl #(
    .DIV       (4),
    .DB_CYCLES (2)
  ) dut (
    .clk_in     (clk_in),
    .sw         (sw),
    .btn_start  (btn_start),
    .btn_lap    (btn_lap),
    .ones_in    (ones_in),
    .tens_in    (tens_in),
    .cnt_tick   (cnt_tick),
    .cnt_clr    (cnt_clr),
    .min_pulse  (min_pulse),
    .disp_ones  (disp_ones),
    .disp_tens  (disp_tens),
    .running    (running),
    .lap_active (lap_active)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Raw level held for 4 edges: 2 sync stages, 2 debounce cycles; state moves on edge 4.
  task automatic press(input logic s, input logic l);
    btn_start = s;
    btn_lap   = l;
    repeat (4) step();
    btn_start = 1'b0;
    btn_lap   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clr"},  8'(cnt_clr),    8'd1);
    chk({tag, "_tick"}, 8'(cnt_tick),   8'd0);
    chk({tag, "_min"},  8'(min_pulse),  8'd0);
    chk({tag, "_run"},  8'(running),    8'd0);
    chk({tag, "_lap"},  8'(lap_active), 8'd0);
    chk({tag, "_disp"}, {disp_tens, disp_ones}, 8'h00);
  endtask

  initial begin
    // Reset held, then 50 idle cycles.
    repeat (3) step();
    chk_reset_vals("rst_held");
    sw = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      step();
      seen = seen | cnt_tick;
    end
    chk("idle_no_tick", 8'(seen), 8'd0);
    chk_reset_vals("idle50");

    // Start: RUN, ticks every 4 cycles, first 4 cycles after the state change (E0).
    press(1'b1, 1'b0);
    chk("run_running", 8'(running), 8'd1);
    chk("run_clr",     8'(cnt_clr), 8'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("run_tick_%0d", i), 8'(cnt_tick), 8'((i % 4) == 0));
    end

    // One-cycle glitch on start: ignored (E13..E19).
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    repeat (6) step();
    chk("glitch_running", 8'(running), 8'd1);

    // Press start -> PAUSE at E23 with prescaler at 3; no ticks for 10 cycles.
    press(1'b1, 1'b0);
    chk("pause_running", 8'(running), 8'd0);
    chk("pause_clr",     8'(cnt_clr), 8'd0);
    seen = 1'b0;
    repeat (10) begin
      step();
      seen = seen | cnt_tick;
    end
    chk("pause_no_tick", 8'(seen), 8'd0);

    // Resume at E37: only one prescaler step remains, tick on E38.
    press(1'b1, 1'b0);
    chk("resume_running", 8'(running),  8'd1);
    chk("resume_tick0",   8'(cnt_tick), 8'd0);
    step();
    chk("resume_tick1",   8'(cnt_tick), 8'd1);

    // Counter at 3/2, lap -> LAP at E42, display frozen while inputs advance.
    ones_in = 4'd3;
    tens_in = 4'd2;
    press(1'b0, 1'b1);
    chk("lap_active",  8'(lap_active), 8'd1);
    chk("lap_running", 8'(running),    8'd1);
    chk("lap_disp0",   {disp_tens, disp_ones}, 8'h23);
    for (int k = 1; k <= 6; k++) begin
      ones_in = 4'(3 + k);
      step();
      chk($sformatf("lap_hold_%0d", k), {disp_tens, disp_ones}, 8'h23);
    end

    // Second lap at E52 -> RUN; display released one cycle later.
    ones_in = 4'd7;
    tens_in = 4'd3;
    press(1'b0, 1'b1);
    chk("unlap_active", 8'(lap_active), 8'd0);
    chk("unlap_disp0",  {disp_tens, disp_ones}, 8'h23);
    step();
    chk("unlap_disp1",  {disp_tens, disp_ones}, 8'h37);

    // Ticks at E54, E58, E62: 5/9 -> min_pulse, 5/8 and 6/9 -> none.
    ones_in = 4'd9;
    tens_in = 4'd5;
    step();
    chk("min59_tick",  8'(cnt_tick),  8'd1);
    chk("min59_pulse", 8'(min_pulse), 8'd1);
    ones_in = 4'd8;
    repeat (3) step();
    chk("min58_pre",   8'(cnt_tick),  8'd0);
    step();
    chk("min58_tick",  8'(cnt_tick),  8'd1);
    chk("min58_pulse", 8'(min_pulse), 8'd0);
    ones_in = 4'd9;
    tens_in = 4'd6;
    repeat (4) step();
    chk("min69_tick",  8'(cnt_tick),  8'd1);
    chk("min69_pulse", 8'(min_pulse), 8'd0);

    // Start and lap together in RUN: start wins -> PAUSE, lap dropped.
    press(1'b1, 1'b1);
    chk("both_running", 8'(running),    8'd0);
    chk("both_lap",     8'(lap_active), 8'd0);
    chk("both_clr",     8'(cnt_clr),    8'd0);
    repeat (6) step();
    chk("both_settled_lap", 8'(lap_active), 8'd0);
    chk("both_settled_clr", 8'(cnt_clr),    8'd0);
    chk("both_disp",        {disp_tens, disp_ones}, 8'h69);

    // Resume, then async reset mid-RUN between clock edges.
    press(1'b1, 1'b0);
    chk("pre_sw_running", 8'(running), 8'd1);
    step();
    #2;
    sw = 1'b1;
    #1;
    chk_reset_vals("sw_async");
    btn_lap = 1'b1;
    repeat (3) step();
    btn_lap = 1'b0;
    sw = 1'b0;
    repeat (8) step();
    chk("post_sw_running", 8'(running), 8'd0);
    chk("post_sw_clr",     8'(cnt_clr), 8'd1);
    chk("post_sw_disp",    {disp_tens, disp_ones}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
